sim_report_gen: RTL

DUT-side simulation status generator. It drives the `sim_success`, `sim_done` and `sim_report` outputs of every simulation `top`, which the common bench harness watches. Test logic inside the DUT submits per-check pass/fail results over a valid/ready handshake. The block tallies the results, publishes an encoded progress word, and asserts done/success exactly once per run.

---
 rtl/sim_report_pkg.sv | 28 ++
 rtl/sim_report_if.sv | 9 +
 rtl/sim_report_wdog.sv | 24 ++
 rtl/sim_report_gen.sv | 81 ++++++++
 4 files changed

// File: rtl/sim_report_pkg.sv
// sim_report_pkg: report tags, run state and report field layout for sim_report_gen
package sim_report_pkg;

   typedef enum logic {RUN, DONE} state_t;

   localparam logic [7:0] TAG_PROG_PASS  = 8'h10;
   localparam logic [7:0] TAG_PROG_FAIL  = 8'hF0;
   localparam logic [7:0] TAG_FINAL_OK   = 8'h5C;
   localparam logic [7:0] TAG_FINAL_FAIL = 8'hFA;
   localparam logic [7:0] TAG_TIMEOUT    = 8'hDE;

   localparam int TAG_LSB  = 24;
   localparam int ID_LSB   = 16;
   localparam int PASS_LSB = 8;
   localparam int FAIL_LSB = 0;

   function automatic logic [31:0] pack_report(input logic [7:0] tag, input logic [7:0] id,
                                               input logic [7:0] pass, input logic [7:0] fail);
      logic [31:0] r;
      r = '0;
      r[TAG_LSB +: 8]  = tag;
      r[ID_LSB +: 8]   = id;
      r[PASS_LSB +: 8] = pass;
      r[FAIL_LSB +: 8] = fail;
      return r;
   endfunction

endpackage

// File: rtl/sim_report_if.sv
// sim_report_if: check-result valid/ready channel from test logic to the report generator
interface sim_report_if;
   logic       chk_valid;
   logic       chk_ready;
   logic       chk_pass;
   logic [7:0] chk_id;
   modport master (output chk_valid, chk_pass, chk_id, input chk_ready);
   modport slave (input chk_valid, chk_pass, chk_id, output chk_ready);
endinterface

// File: rtl/sim_report_wdog.sv
// sim_report_wdog: idle-cycle counter that flags expiry when a run stalls without accepted checks
module sim_report_wdog #(
   parameter int CYCLES = 100000
) (
   input  logic refclk,
   input  logic rst,
   input  logic run,
   input  logic accept,
   output logic expire
);
   localparam int W = $clog2(CYCLES);

   logic [W-1:0] cnt;

   // an accept in the expiry cycle wins, so it masks the pulse
   assign expire = run & ~accept & (cnt == W'(CYCLES - 1));

   // count idle RUN cycles, restart on every accepted check
   always_ff @(posedge refclk or negedge rst)
      if (!rst) cnt <= '0;
      else if (accept) cnt <= '0;
      else if (run) cnt <= cnt + W'(1);

endmodule

// File: rtl/sim_report_gen.sv
// sim_report_gen: tallies check results and drives sim_done/sim_success/sim_report; SIM_REPORT_WATCHDOG_EN adds an idle timeout
module sim_report_gen
   import sim_report_pkg::*;
#(
   parameter int NUM_CHECKS  = 16,
   parameter int WDOG_CYCLES = 100000
) (
   input  logic              refclk,
   input  logic              rst,
   sim_report_if.slave       chk,
   input  logic              end_req,
   output logic              sim_success,
   output logic              sim_done,
   output logic [31:0]       sim_report
);
   state_t      state, state_n;
   logic        ready, ready_n;
   logic        accept, expire, finish, success_n;
   logic [7:0]  pass_cnt, pass_n, fail_cnt, fail_n, seen_cnt, seen_n, id_n;
   logic [31:0] report_n;

   if (NUM_CHECKS < 1 || NUM_CHECKS > 255 || WDOG_CYCLES < 2) begin : g_bad_cfg
      $error("sim_report_gen: parameter out of range");
   end

   assign chk.chk_ready = ready;
   assign sim_done      = (state == DONE);
   assign accept        = chk.chk_valid & ready;

`ifdef SIM_REPORT_WATCHDOG_EN
   sim_report_wdog #(.CYCLES(WDOG_CYCLES)) u_wdog (
      .refclk (refclk),
      .rst    (rst),
      .run    (state == RUN),
      .accept (accept),
      .expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // count the accepted check first, then decide whether this edge ends the run
   always_comb begin
      pass_n    = (accept & chk.chk_pass & (pass_cnt != 8'hFF)) ? pass_cnt + 8'd1 : pass_cnt;
      fail_n    = (accept & ~chk.chk_pass & (fail_cnt != 8'hFF)) ? fail_cnt + 8'd1 : fail_cnt;
      seen_n    = accept ? seen_cnt + 8'd1 : seen_cnt;
      id_n      = accept ? chk.chk_id : sim_report[ID_LSB +: 8];
      finish    = (state == RUN) & ((accept & (seen_n == 8'(NUM_CHECKS))) | end_req | expire);
      success_n = finish & ~expire & (fail_n == 8'd0) & (pass_n == 8'(NUM_CHECKS));
      state_n   = finish ? DONE : state;
      ready_n   = (state_n == RUN);
      report_n  = expire ? pack_report(TAG_TIMEOUT, id_n, pass_n, fail_n) :
                  finish ? pack_report(success_n ? TAG_FINAL_OK : TAG_FINAL_FAIL, id_n, pass_n, fail_n) :
                  accept ? pack_report(chk.chk_pass ? TAG_PROG_PASS : TAG_PROG_FAIL, id_n, pass_n, fail_n) :
                  sim_report;
   end

   // run state; DONE is sticky until reset
   always_ff @(posedge refclk or negedge rst)
      if (!rst) state <= RUN;
      else state <= state_n;

   // tallies, report word and handshake; ready is registered so it rises one clock after reset release
   always_ff @(posedge refclk or negedge rst)
      if (!rst) begin
         ready       <= 1'b0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         seen_cnt    <= '0;
         sim_report  <= '0;
         sim_success <= 1'b0;
      end else begin
         ready       <= ready_n;
         pass_cnt    <= pass_n;
         fail_cnt    <= fail_n;
         seen_cnt    <= seen_n;
         sim_report  <= report_n;
         sim_success <= sim_success | success_n;
      end

endmodule
